// File: rtl/restrict_pkg.sv
// Shared types and helpers for the restrict_unit request/acknowledge responder.
package restrict_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DROP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_EARLY_DROP = 2'd1,
    ERR_LATE_DROP  = 2'd2
  } err_code_e;

  // Down-counter holds N-1, and the longest latency is 8 cycles.
  localparam int unsigned CNT_W = 3;

  function automatic logic [3:0] delay_cycles(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

endpackage

// File: rtl/restrict_proto_chk.sv
// Sticky protocol-error recorder plus handshake assertions for restrict_unit.
// Compiled only when RESTRICT_PROTO_CHECK_EN is defined.
`ifdef RESTRICT_PROTO_CHECK_EN
module restrict_proto_chk
  import restrict_pkg::*;
#(
  parameter int unsigned CTR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  state_e           state_i,
  input  logic             req_i,
  input  logic             ack_i,
  input  logic             clr_i,
  input  logic [CTR_W-1:0] ctr_i,
  output logic             err_o,
  output logic [1:0]       err_code_o
);

  logic      err_q;
  err_code_e code_q;
  logic      ack_seen_q;
  logic      early_drop;
  logic      late_drop;
  err_code_e new_code;

  // ack_seen_q marks the first DROP cycle, the only one where a held req is an error.
  assign early_drop = (state_i == WAIT) && !req_i;
  assign late_drop  = (state_i == DROP) && ack_seen_q && req_i;

  always_comb begin
    new_code = ERR_NONE;
    if (early_drop)     new_code = ERR_EARLY_DROP;
    else if (late_drop) new_code = ERR_LATE_DROP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      ack_seen_q <= 1'b0;
    end else begin
      ack_seen_q <= ack_i;
      if (clr_i) begin
        // An error arriving together with clr survives the clear.
        err_q  <= (new_code != ERR_NONE);
        code_q <= new_code;
      end else if (!err_q && (new_code != ERR_NONE)) begin
        err_q  <= 1'b1;
        code_q <= new_code;
      end
    end
  end

  assign err_o      = err_q;
  assign err_code_o = code_q;

  a_ack_needs_req : assert property (@(posedge clk) disable iff (!rst_n)
    ack_i |-> $past(req_i));
  a_ack_single    : assert property (@(posedge clk) disable iff (!rst_n)
    ack_i |=> !ack_i);
  a_clr_zeroes    : assert property (@(posedge clk) disable iff (!rst_n)
    clr_i |=> (ctr_i == '0));

endmodule
`endif

// File: rtl/restrict_unit.sv
// Request/acknowledge responder with programmable 1/2/4/8-cycle latency and a
// completed-handshake counter. Define RESTRICT_PROTO_CHECK_EN for the protocol checker.
module restrict_unit
  import restrict_pkg::*;
#(
  parameter int unsigned CTR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [1:0]       delay,
  input  logic             clr,
  output logic             ack,
  output logic             busy,
  output logic [CTR_W-1:0] ctr,
  output logic             err,
  output logic [1:0]       err_code
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, busy_q;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [3:0]       n_cycles;

  assign n_cycles = delay_cycles(delay);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = CNT_W'(n_cycles - 4'd1);
          state_d = (n_cycles == 4'd1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ACK;
        end
      end
      ACK:  state_d = DROP;
      DROP: if (!req) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear wins over the increment taken when leaving ACK.
  always_comb begin
    ctr_d = ctr_q;
    if (clr)                  ctr_d = '0;
    else if (state_q == ACK)  ctr_d = ctr_q + CTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == ACK);
      busy_q  <= (state_d != IDLE);
      ctr_q   <= ctr_d;
    end
  end

  assign ack  = ack_q;
  assign busy = busy_q;
  assign ctr  = ctr_q;

`ifdef RESTRICT_PROTO_CHECK_EN
  restrict_proto_chk #(
    .CTR_W (CTR_W)
  ) u_proto_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .state_i    (state_q),
    .req_i      (req),
    .ack_i      (ack_q),
    .clr_i      (clr),
    .ctr_i      (ctr_q),
    .err_o      (err),
    .err_code_o (err_code)
  );
`else
  assign err      = 1'b0;
  assign err_code = 2'd0;
`endif

endmodule

// File: tb/tb_restrict_unit.sv
// Self-checking bench for restrict_unit: expected ack cycles queued at request time.
module tb_restrict_unit;

  localparam int CTR_W = 4;
`ifdef RESTRICT_PROTO_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             req   = 1'b0;
  logic [1:0]       delay = 2'd0;
  logic             clr   = 1'b0;
  logic             ack;
  logic             busy;
  logic [CTR_W-1:0] ctr;
  logic             err;
  logic [1:0]       err_code;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int exp_ctr = 0;
  int exp_q[$];

  restrict_unit #(.CTR_W(CTR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .delay    (delay),
    .clr      (clr),
    .ack      (ack),
    .busy     (busy),
    .ctr      (ctr),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every ack must match the oldest outstanding expected ack cycle.
  always @(negedge clk) begin
    if (ack) begin
      if (exp_q.size() == 0) check("ack_spurious", 32'd1, 32'd0);
      else                   check("ack_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic wait_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = ack;
      check("busy_wait", busy, 1);
    end
    check("ack_timeout", seen, 1);
  endtask

  task automatic finish_hs(input int hold, input bit clr_on_ack);
    wait_ack();
    if (clr_on_ack) clr = 1'b1;
    delay = ~delay;
    @(negedge clk);
    clr = 1'b0;
    exp_ctr = clr_on_ack ? 0 : (exp_ctr + 1) % (1 << CTR_W);
    check("ctr_after_ack", ctr, exp_ctr);
    check("ack_single", ack, 0);
    repeat (hold) begin
      @(negedge clk);
      check("busy_hold", busy, 1);
    end
    req = 1'b0;
    @(negedge clk);
    check("busy_idle", busy, 0);
  endtask

  task automatic handshake(input logic [1:0] d, input int hold, input bit clr_on_ack);
    @(negedge clk);
    req   = 1'b1;
    delay = d;
    exp_q.push_back(cyc + (1 << d));
    finish_hs(hold, clr_on_ack);
  endtask

  task automatic abort_req();
    @(negedge clk);
    req   = 1'b1;
    delay = 2'd2;
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    repeat (4) @(negedge clk);
    check("abort_ctr", ctr, exp_ctr);
  endtask

  task automatic clear_all();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_ctr = 0;
    check("clr_ctr", ctr, 0);
    check("clr_err", err, 0);
    check("clr_code", err_code, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_ctr", ctr, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    @(negedge clk);
    rst_n = 1'b1;

    handshake(2'd0, 0, 1'b0);
    check("hs0_err", err, 0);
    handshake(2'd3, 0, 1'b0);
    handshake(2'd1, 0, 1'b0);
    handshake(2'd2, 0, 1'b0);

    abort_req();
    check("early_err", err, CHK_EN ? 32'd1 : 32'd0);
    check("early_code", err_code, CHK_EN ? 32'd1 : 32'd0);
    clear_all();

    handshake(2'd0, 3, 1'b0);
    check("late_err", err, CHK_EN ? 32'd1 : 32'd0);
    check("late_code", err_code, CHK_EN ? 32'd2 : 32'd0);
    abort_req();
    check("sticky_code", err_code, CHK_EN ? 32'd2 : 32'd0);
    clear_all();

    for (int i = 0; i < 16; i++) handshake(2'(i % 4), 0, 1'b0);
    check("ctr_wrap", ctr, 0);

    handshake(2'd1, 0, 1'b0);
    handshake(2'd2, 0, 1'b1);

    handshake(2'd0, 0, 1'b0);
    abort_req();
    @(negedge clk);
    req   = 1'b1;
    delay = 2'd3;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_ctr = 0;
    check("rstw_ack", ack, 0);
    check("rstw_busy", busy, 0);
    check("rstw_ctr", ctr, 0);
    check("rstw_err", err, 0);
    check("rstw_code", err_code, 0);
    @(negedge clk);
    check("rstw_hold_busy", busy, 0);
    delay = 2'd0;
    rst_n = 1'b1;
    exp_q.push_back(cyc + 1);
    finish_hs(0, 1'b0);

    repeat (4) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
